gray_step_ctrl: RTL and testbench

- Upstream stage for gray_4bits: generates its clk_en input from two board push-buttons.
- Two modes: free-run at a slow divided rate, or paused with single-step on button press.
- Output drives gray_4bits clk_en directly; running drives a status LED.

---
 rtl/gray_step_ctrl_pkg.sv | 7 +
 rtl/gray_step_ctrl_btn_debounce.sv | 38 +++
 rtl/gray_step_ctrl.sv | 49 ++++
 tb/tb_gray_step_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/gray_step_ctrl_pkg.sv
// gray_step_ctrl_pkg: shared state encoding and counter width helper
package gray_step_ctrl_pkg;
  typedef enum logic {ST_PAUSE = 1'b0, ST_RUN = 1'b1} state_t;
  function automatic int cw(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/gray_step_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability debounce and rising-edge press pulse
module btn_debounce
  import gray_step_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = cw(DEB_CYCLES);
  logic [1:0] sync_q, sync_d;
  logic deb_q, deb_d, deb_d1_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic diff, done;
  always_comb begin
    sync_d = {sync_q[0], btn};
    diff = sync_q[1] != deb_q;
    done = diff && (cnt_q == CW'(DEB_CYCLES - 1));
    deb_d = done ? sync_q[1] : deb_q;
    cnt_d = (diff && !done) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      deb_q <= 1'b0;
      deb_d1_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      deb_q <= deb_d;
      deb_d1_q <= deb_q;
      cnt_q <= cnt_d;
    end
  end
  assign press = deb_q & ~deb_d1_q;
endmodule

// File: rtl/gray_step_ctrl.sv
// gray_step_ctrl: run/pause FSM with divided free-run and single-step clk_en
module gray_step_ctrl
  import gray_step_ctrl_pkg::*;
#(
  parameter int DIV        = 100000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_step,
  output logic clk_en,
  output logic running
);
  localparam int DW = cw(DIV);
  state_t state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic clk_en_q, clk_en_d, running_q, running_d;
  logic run_press, step_press, wrap;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run (
    .clk(clk), .rst(rst), .btn(btn_run), .press(run_press)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .clk(clk), .rst(rst), .btn(btn_step), .press(step_press)
  );
  // run_press wins over everything: toggles state, clears divider, suppresses any pulse
  always_comb begin
    wrap = cnt_q == DW'(DIV - 1);
    state_d = run_press ? ((state_q == ST_RUN) ? ST_PAUSE : ST_RUN) : state_q;
    cnt_d = (state_q == ST_RUN && !run_press && !wrap) ? cnt_q + 1'b1 : '0;
    clk_en_d = run_press ? 1'b0 : (state_q == ST_RUN) ? wrap : step_press;
    running_d = state_d == ST_RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PAUSE;
      cnt_q <= '0;
      clk_en_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      clk_en_q <= clk_en_d;
      running_q <= running_d;
    end
  end
  assign clk_en = clk_en_q;
  assign running = running_q;
endmodule

// File: tb/tb_gray_step_ctrl.sv
// tb_gray_step_ctrl: directed + random stimulus checked against a history-based reference model
module tb_gray_step_ctrl;
  localparam int DIV = 4;
  localparam int DEB = 3;
  logic clk = 1'b0, rst = 1'b1, btn_run = 1'b0, btn_step = 1'b0;
  logic clk_en, running;
  int checks = 0, errors = 0, pulses = 0;
  bit hr[$], hs[$];
  bit dr, pdr, ds, pds, m_run, m_en;
  int entry;

  gray_step_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
    .clk_en(clk_en), .running(running)
  );

  always #5 clk = ~clk;

  function automatic bit smp(input bit which, input int i);
    if (i < 0) return 1'b0;
    return which ? hs[i] : hr[i];
  endfunction

  // a level is accepted once the synchronized input has differed from it for DEB straight edges
  function automatic bit accept(input bit which, input bit lvl);
    int e = hr.size();
    for (int j = 0; j < DEB; j++) if (smp(which, e - 2 - j) == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input bit r, input bit br, input bit bs);
    bit pr, ps, nr, ns;
    int e;
    @(negedge clk);
    rst = r; btn_run = br; btn_step = bs;
    @(posedge clk);
    if (r) begin
      hr.delete(); hs.delete();
      dr = 0; pdr = 0; ds = 0; pds = 0; m_run = 0; m_en = 0;
    end else begin
      e = hr.size();
      pr = dr & ~pdr;
      ps = ds & ~pds;
      nr = dr ^ accept(1'b0, dr);
      ns = ds ^ accept(1'b1, ds);
      pdr = dr; dr = nr; pds = ds; ds = ns;
      if (pr) begin m_run = !m_run; entry = e; m_en = 0; end
      else if (!m_run) m_en = ps;
      else m_en = ((e - entry) % DIV) == 0;
      hr.push_back(br); hs.push_back(bs);
    end
    #1;
    if (clk_en === 1'b1) pulses++;
    check("clk_en", clk_en, m_en);
    check("running", running, m_run);
  endtask

  task automatic hold(input bit br, input bit bs, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, br, bs);
  endtask

  initial begin
    // reset with buttons toggling, then idle
    tick(1, 1, 0); tick(1, 0, 1);
    pulses = 0;
    hold(0, 0, 20);
    check_int("idle_pulses", pulses, 0);
    // three single steps in PAUSE
    pulses = 0;
    for (int k = 0; k < 3; k++) begin hold(0, 1, 10); hold(0, 0, 10); end
    check_int("step_pulses", pulses, 3);
    check("step_running", running, 1'b0);
    // run/pause with the stop press landing at every divider phase
    for (int d = 0; d < DIV; d++) begin
      hold(1, 0, 6); hold(0, 0, 12 + d);
      check("run_entered", running, 1'b1);
      hold(1, 0, 6); hold(0, 0, 10);
      check("run_left", running, 1'b0);
    end
    // glitches of 1 and 2 cycles are rejected, 3 cycles accepted
    pulses = 0;
    hold(0, 1, 1); hold(0, 0, 10);
    hold(0, 1, 2); hold(0, 0, 10);
    check_int("glitch_pulses", pulses, 0);
    hold(0, 1, 3); hold(0, 0, 10);
    check_int("deb3_pulses", pulses, 1);
    // bouncing then stable high
    pulses = 0;
    for (int i = 0; i < 8; i++) tick(0, 0, i[0] ? 1'b0 : 1'b1);
    hold(0, 1, 10); hold(0, 0, 10);
    check_int("bounce_pulses", pulses, 1);
    // simultaneous press: run wins, no step pulse
    pulses = 0;
    hold(1, 1, 6);
    check("both_running", running, 1'b1);
    check_int("both_pulses", pulses, 0);
    hold(0, 0, 6);
    // step presses during RUN leave spacing intact
    hold(0, 1, 7); hold(0, 0, 9);
    // reset mid-RUN, then reset inside a debounce window
    tick(1, 0, 0);
    check("rst_running", running, 1'b0);
    check("rst_clk_en", clk_en, 1'b0);
    pulses = 0;
    hold(0, 1, 3);
    tick(1, 0, 0);
    hold(0, 0, 12);
    check_int("rst_window_pulses", pulses, 0);
    // randomized sticky-button traffic with occasional reset
    begin
      bit br = 0, bs = 0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 5) == 0) br = !br;
        if ($urandom_range(0, 4) == 0) bs = !bs;
        tick($urandom_range(0, 299) == 0, br, bs);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
